bomb_keypad_defuser: RTL
========================

Name: bomb_keypad_defuser

Overview:
Input-side counterpart of the bomb LED-matrix display. It scans a 4x4 active-low keypad matrix, debounces key presses, and runs the defuse-code entry state machine. It drives the display's fuse `start` line and reports the outcome as defused or boom. It samples the display's `fail` flag to detect fuse burn-out.

Parameters:
SCAN_DIV, 50, clk cycles per column step; legal range >=2.
DEB_FRAMES, 4, consecutive identical full-scan frames required to accept a key; legal range >=1.
CODE, 16'h1234, 4-digit defuse code, one nibble per digit, first digit in [15:12].
MAX_TRIES, 3, wrong ENT attempts before boom; legal range 1..7.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
bomb_on  in  1  master enable; 0 = block idle and cleared
arm  in  1  level; rising edge while IDLE arms the bomb
fail  in  1  fuse burned out, from the display block
row  in  4  keypad rows, active-low (pulled up)
col  out  4  keypad column drive, active-low, one-hot-low
key_valid  out  1  one-cycle pulse when a debounced key is accepted
key_code  out  4  accepted key = row_idx*4 + col_idx; valid with key_valid, held after
start  out  1  fuse run enable to display; 1 only in ENTRY
defused  out  1  level, 1 in DEFUSED
boom  out  1  level, 1 in BOOM
tries  out  3  wrong attempts so far
digits  out  3  digits entered in current attempt, 0..4

Behaviour:
- Reset values (rst=1 at clk edge, or bomb_on=0): col=4'b1111 when bomb_on=0, col=4'b1110 after rst with bomb_on=1. key_valid=0, key_code=0, start=0, defused=0, boom=0, tries=0, digits=0, state=IDLE. Divider, debounce and code registers all cleared. rst has priority over everything.
- Scan: divider counts 0..SCAN_DIV-1. At the terminal count (tick), sample row for the current column, then rotate col 1110->1101->1011->0111->1110. One frame = 4 ticks, ending at the col=0111 tick.
- Frame result: exactly one low row bit across the frame gives key = row_idx*4 + col_idx, where row_idx is the low bit position in row and col_idx is the low bit position in col. Zero low bits gives NONE. Two or more low bits gives NONE (ghost rejection).
- Debounce: each frame-end compares the frame key to the previous frame key. Equal and not NONE increments the match counter; otherwise the counter reloads to 1 (or 0 if NONE). When the counter reaches DEB_FRAMES and the key is not yet latched: key_valid=1 for the next cycle only, key_code updated, latched set. latched clears on the first NONE frame. A held key never repeats.
- Key classes: 0x0-0x9 are digits; 0xE = CLR; 0xF = ENT; 0xA-0xD are ignored.
- FSM:
  - IDLE: arm rising edge (arm registered, 0->1) -> ENTRY. Keys ignored.
  - ENTRY: start=1.
    - Digit with digits<4: shift into a 16-bit entry register (left shift, new nibble in [3:0]), digits++.
    - Digit with digits==4: ignored.
    - CLR: digits=0, entry=0.
    - ENT with digits==4 and entry==CODE -> DEFUSED.
    - ENT otherwise is wrong: tries++, digits=0, entry=0. If the new tries==MAX_TRIES -> BOOM.
  - fail=1 in ENTRY -> BOOM. fail has priority over a same-cycle key_valid.
  - DEFUSED: start=0, defused=1. Held until rst or bomb_on=0. fail ignored.
  - BOOM: start=0, boom=1. Held until rst or bomb_on=0.
- FSM acts on key_valid in the same cycle key_valid is high. defused, boom and start are registered: they change the cycle after the deciding key_valid or fail.
- tries saturates at MAX_TRIES. digits never exceeds 4.

Optional Feature:
Macro: WRONG_PENALTY_EN.
- Defined: adds output port `penalty` (1 bit). penalty pulses high for exactly 1 cycle on each wrong ENT that does not cause BOOM. The display uses it to burn one fuse row early.
- Undefined: port absent; wrong ENT affects only tries.

Test Plan:
1. SCAN_DIV=4, DEB_FRAMES=2, bomb_on=1, rst pulse: col steps 1110,1101,1011,0111 every 4 clks; all outputs 0; pulse arm -> start=1 next cycle, digits=0.
2. Press key row1/col2 (row=1101 while col=1011) held 5 frames: exactly one key_valid, key_code=6, digits=1. Release 1 frame and press again: second key_valid.
3. Enter 1,2,3,4 then F (ENT): digits 1..4, then defused=1 and start=0 one cycle after the ENT key_valid; later fail=1 leaves boom=0.
4. MAX_TRIES=3: enter 1,2,3,5,ENT three times -> tries 1,2,3; boom=1 after the third ENT. With WRONG_PENALTY_EN, penalty pulses only after the first two.
5. Enter 9,9, CLR, 1,2,3,4,7,ENT: CLR gives digits=0; the fifth digit (7) is ignored; defused=1. Pressing row1 and row2 in the same column gives no key_valid.
6. In ENTRY, assert fail in the same cycle as the ENT key_valid of the correct code: boom=1, defused=0. Then rst=1 for 1 clk: all outputs return to reset values, state IDLE.

Source files
------------

// File: rtl/bomb_keypad_defuser.sv
// Keypad scanner, frame debouncer and defuse-code entry FSM for the bomb display.
// Optional macro WRONG_PENALTY_EN adds the one-cycle penalty output.
module bomb_keypad_defuser #(
    parameter int unsigned SCAN_DIV   = 50,
    parameter int unsigned DEB_FRAMES = 4,
    parameter logic [15:0] CODE       = 16'h1234,
    parameter int unsigned MAX_TRIES  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bomb_on,
    input  logic       arm,
    input  logic       fail,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       start,
    output logic       defused,
    output logic       boom,
    output logic [2:0] tries,
    output logic [2:0] digits
`ifdef WRONG_PENALTY_EN
   ,output logic       penalty
`endif
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_FRAMES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTRY,
        S_DEFUSED,
        S_BOOM
    } state_t;

    logic [DW-1:0] div_q;
    logic [1:0]    colidx_q;
    logic [1:0]    fnum_q;
    logic [3:0]    fkey_q;
    logic          prev_hit_q;
    logic [3:0]    prev_key_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          latched_q;
    logic          kv_q;
    logic [3:0]    key_q;

    logic          tick;
    logic          frame_end;
    logic [2:0]    s_cnt;
    logic [1:0]    s_row;
    logic [2:0]    sum;
    logic [1:0]    acc_num;
    logic [3:0]    acc_key;
    logic          f_hit;

    state_t        state_q;
    logic          arm_q;
    logic          start_q;
    logic          defused_q;
    logic          boom_q;
    logic [2:0]    tries_q;
    logic [2:0]    digits_q;
    logic [15:0]   entry_q;
    logic [2:0]    tries_inc;
`ifdef WRONG_PENALTY_EN
    logic          pen_q;
`endif

    assign tick      = (div_q == DW'(SCAN_DIV - 1));
    assign frame_end = tick && (colidx_q == 2'd3);

    always_comb begin
        s_cnt = '0;
        s_row = '0;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) begin
                s_cnt = s_cnt + 3'd1;
                s_row = 2'(r);
            end
        end
    end

    // Low bits accumulate across the frame; two or more means a ghosted press.
    assign sum     = {1'b0, fnum_q} + s_cnt;
    assign acc_num = (sum > 3'd1) ? 2'd2 : sum[1:0];
    assign acc_key = (s_cnt != 3'd0) ? {s_row, colidx_q} : fkey_q;
    assign f_hit   = (acc_num == 2'd1);

    always_comb begin
        if (!f_hit)
            cnt_d = '0;
        else if (prev_hit_q && (acc_key == prev_key_q))
            cnt_d = (cnt_q >= CW'(DEB_FRAMES)) ? cnt_q : cnt_q + CW'(1);
        else
            cnt_d = CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || !bomb_on) begin
            div_q      <= '0;
            colidx_q   <= '0;
            fnum_q     <= '0;
            fkey_q     <= '0;
            prev_hit_q <= 1'b0;
            prev_key_q <= '0;
            cnt_q      <= '0;
            latched_q  <= 1'b0;
            kv_q       <= 1'b0;
            key_q      <= '0;
        end else begin
            kv_q  <= 1'b0;
            div_q <= tick ? '0 : div_q + DW'(1);
            if (tick) begin
                colidx_q <= colidx_q + 2'd1;
                if (frame_end) begin
                    fnum_q     <= '0;
                    fkey_q     <= '0;
                    prev_hit_q <= f_hit;
                    prev_key_q <= acc_key;
                    cnt_q      <= cnt_d;
                    if (!f_hit) begin
                        latched_q <= 1'b0;
                    end else if ((cnt_d >= CW'(DEB_FRAMES)) && !latched_q) begin
                        kv_q      <= 1'b1;
                        key_q     <= acc_key;
                        latched_q <= 1'b1;
                    end
                end else begin
                    fnum_q <= acc_num;
                    fkey_q <= acc_key;
                end
            end
        end
    end

    assign tries_inc = tries_q + 3'd1;

    always_ff @(posedge clk) begin
        if (rst || !bomb_on) begin
            state_q   <= S_IDLE;
            arm_q     <= 1'b0;
            start_q   <= 1'b0;
            defused_q <= 1'b0;
            boom_q    <= 1'b0;
            tries_q   <= '0;
            digits_q  <= '0;
            entry_q   <= '0;
`ifdef WRONG_PENALTY_EN
            pen_q     <= 1'b0;
`endif
        end else begin
            arm_q <= arm;
`ifdef WRONG_PENALTY_EN
            pen_q <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (arm && !arm_q) begin
                        state_q <= S_ENTRY;
                        start_q <= 1'b1;
                    end
                end
                S_ENTRY: begin
                    if (fail) begin
                        state_q <= S_BOOM;
                        start_q <= 1'b0;
                        boom_q  <= 1'b1;
                    end else if (kv_q) begin
                        if (key_q <= 4'd9) begin
                            if (digits_q != 3'd4) begin
                                entry_q  <= {entry_q[11:0], key_q};
                                digits_q <= digits_q + 3'd1;
                            end
                        end else if (key_q == 4'hE) begin
                            entry_q  <= '0;
                            digits_q <= '0;
                        end else if (key_q == 4'hF) begin
                            if ((digits_q == 3'd4) && (entry_q == CODE)) begin
                                state_q   <= S_DEFUSED;
                                start_q   <= 1'b0;
                                defused_q <= 1'b1;
                            end else begin
                                tries_q  <= tries_inc;
                                entry_q  <= '0;
                                digits_q <= '0;
                                if (tries_inc == 3'(MAX_TRIES)) begin
                                    state_q <= S_BOOM;
                                    start_q <= 1'b0;
                                    boom_q  <= 1'b1;
                                end else begin
`ifdef WRONG_PENALTY_EN
                                    pen_q <= 1'b1;
`endif
                                end
                            end
                        end
                    end
                end
                S_DEFUSED: begin
                end
                S_BOOM: begin
                end
            endcase
        end
    end

    assign col       = bomb_on ? ~(4'b0001 << colidx_q) : 4'b1111;
    assign key_valid = kv_q;
    assign key_code  = key_q;
    assign start     = start_q;
    assign defused   = defused_q;
    assign boom      = boom_q;
    assign tries     = tries_q;
    assign digits    = digits_q;
`ifdef WRONG_PENALTY_EN
    assign penalty   = pen_q;
`endif

endmodule
